// File: rtl/difftest_if.sv
// Commit-stream bus between the sim harness and the difftest checker.
// Carries the DUT retirement stream (no backpressure) and the reference
// commit stream (valid/ready).
//   master: harness side, drives both commit streams, observes ref_ready
//   slave : checker side, consumes both streams, drives ref_ready
interface difftest_if #(
    parameter int XLEN = 32
);
    logic            dut_valid;
    logic [XLEN-1:0] dut_pc;
    logic            dut_wen;
    logic [4:0]      dut_rd;
    logic [XLEN-1:0] dut_wdata;

    logic            ref_valid;
    logic            ref_ready;
    logic [XLEN-1:0] ref_pc;
    logic            ref_wen;
    logic [4:0]      ref_rd;
    logic [XLEN-1:0] ref_wdata;

    modport master (
        output dut_valid, dut_pc, dut_wen, dut_rd, dut_wdata,
        output ref_valid, ref_pc, ref_wen, ref_rd, ref_wdata,
        input  ref_ready
    );

    modport slave (
        input  dut_valid, dut_pc, dut_wen, dut_rd, dut_wdata,
        input  ref_valid, ref_pc, ref_wen, ref_rd, ref_wdata,
        output ref_ready
    );
endinterface

// File: rtl/difftest_checker.sv
// Difftest commit-stream checker. Buffers DUT retirements in a FIFO, pops
// one entry per reference handshake, compares PC and GPR writeback and
// halts with a latched error record on the first divergence.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   enable        checker active; dropping it flushes the FIFO
//   bus           difftest_if slave (DUT commits in, ref commits in, ref_ready out)
//   halt          sticky stop-on-error flag
//   err_code      0 none, 1 PC mismatch, 2 writeback mismatch, 3 FIFO overflow
//   err_pc, err_dut_data, err_ref_data   latched failure record
//   match_cnt     commits compared equal (wraps)
//   fifo_level    registered FIFO occupancy
module difftest_checker #(
    parameter int  XLEN  = 32,
    parameter int  DEPTH = 8,
    parameter int  CNT_W = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    difftest_if.slave        bus,
    output logic             halt,
    output logic [1:0]       err_code,
    output logic [XLEN-1:0]  err_pc,
    output logic [XLEN-1:0]  err_dut_data,
    output logic [XLEN-1:0]  err_ref_data,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LW-1:0]    fifo_level
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            wen;
        logic [4:0]      rd;
        logic [XLEN-1:0] wdata;
    } entry_t;

    entry_t mem [DEPTH];

    state_t            state_reg, state_next;
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]     level_reg;
    logic [CNT_W-1:0]  match_cnt_reg;
    logic [1:0]        err_code_reg, err_code_next;
    logic [XLEN-1:0]   err_pc_reg, err_pc_next;
    logic [XLEN-1:0]   err_dut_reg, err_dut_next;
    logic [XLEN-1:0]   err_ref_reg, err_ref_next;

    logic   ready_c, push, pop, flush, match_inc;
    logic   dut_w, ref_w, pc_bad, wb_bad, full;
    entry_t head;

    // Head is read straight from the array; an entry written at an edge is
    // therefore first visible in the following cycle.
    assign head    = mem[rd_ptr_reg];
    assign ready_c = (state_reg == S_RUN) && (level_reg != '0);
    assign full    = (level_reg == LW'(DEPTH));

    // A write to x0 is architecturally a no-write on both sides.
    assign dut_w  = head.wen && (head.rd != 5'd0);
    assign ref_w  = bus.ref_wen && (bus.ref_rd != 5'd0);
    assign pc_bad = (head.pc != bus.ref_pc);
    assign wb_bad = (dut_w != ref_w) ||
                    (dut_w && ((head.rd != bus.ref_rd) || (head.wdata != bus.ref_wdata)));

    always_comb begin
        state_next    = state_reg;
        err_code_next = err_code_reg;
        err_pc_next   = err_pc_reg;
        err_dut_next  = err_dut_reg;
        err_ref_next  = err_ref_reg;
        push          = 1'b0;
        pop           = bus.ref_valid && ready_c;
        flush         = 1'b0;
        match_inc     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (enable) state_next = S_RUN;
            end
            S_RUN: begin
                if (pop && (pc_bad || wb_bad)) begin
                    // Mismatch outranks both overflow and a dropping enable.
                    state_next    = S_HALT;
                    err_code_next = pc_bad ? 2'd1 : 2'd2;
                    err_pc_next   = head.pc;
                    err_dut_next  = head.wdata;
                    err_ref_next  = bus.ref_wdata;
                end else if (bus.dut_valid && full && !pop) begin
                    state_next    = S_HALT;
                    err_code_next = 2'd3;
                    err_pc_next   = bus.dut_pc;
                    err_dut_next  = '0;
                    err_ref_next  = '0;
                end else begin
                    push      = bus.dut_valid;
                    match_inc = pop;
                    if (!enable) begin
                        state_next = S_IDLE;
                        flush      = 1'b1;
                    end
                end
            end
            default: ; // S_HALT: sticky until reset
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            match_cnt_reg <= '0;
            err_code_reg  <= '0;
            err_pc_reg    <= '0;
            err_dut_reg   <= '0;
            err_ref_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            err_code_reg <= err_code_next;
            err_pc_reg   <= err_pc_next;
            err_dut_reg  <= err_dut_next;
            err_ref_reg  <= err_ref_next;
            if (match_inc) match_cnt_reg <= match_cnt_reg + CNT_W'(1);
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
            end else begin
                // Pointers wrap naturally because DEPTH is a power of two.
                wr_ptr_reg <= wr_ptr_reg + AW'(push);
                rd_ptr_reg <= rd_ptr_reg + AW'(pop);
                level_reg  <= level_reg + LW'(push) - LW'(pop);
            end
        end
    end

    // Storage has no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= '{pc: bus.dut_pc, wen: bus.dut_wen,
                                       rd: bus.dut_rd, wdata: bus.dut_wdata};
    end

    assign bus.ref_ready = ready_c;
    assign halt          = (state_reg == S_HALT);
    assign err_code      = err_code_reg;
    assign err_pc        = err_pc_reg;
    assign err_dut_data  = err_dut_reg;
    assign err_ref_data  = err_ref_reg;
    assign match_cnt     = match_cnt_reg;
    assign fifo_level    = level_reg;

endmodule

// File: tb/tb_difftest_checker.sv
module tb_difftest_checker;
    localparam int XLEN = 32, DEPTH = 8, CNT_W = 32, LW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst, enable;
    logic             halt;
    logic [1:0]       err_code;
    logic [XLEN-1:0]  err_pc, err_dut_data, err_ref_data;
    logic [CNT_W-1:0] match_cnt;
    logic [LW-1:0]    fifo_level;

    always #5 clk = ~clk;

    difftest_if #(.XLEN(XLEN)) bus();

    difftest_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bus(bus),
        .halt(halt), .err_code(err_code), .err_pc(err_pc),
        .err_dut_data(err_dut_data), .err_ref_data(err_ref_data),
        .match_cnt(match_cnt), .fifo_level(fifo_level)
    );

    typedef struct {
        logic [31:0] pc;
        bit          wen;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } commit_t;

    typedef struct {
        bit do_rst; bit en;
        bit dv; commit_t dc;
        bit rv; commit_t rc;
        bit e_halt; int e_code; logic [31:0] e_pc, e_dut, e_ref;
        int e_cnt; int e_level; bit e_ready;
    } vec_t;

    int n_cmp = 0, n_bad = 0;

    // Reference model: a queue of pending commits plus the error record.
    commit_t     mq[$];
    bit          m_run, m_halt;
    bit [31:0]   m_cnt;
    int          m_code;
    logic [31:0] m_epc, m_edut, m_eref;

    function automatic commit_t mk(logic [31:0] pc, bit wen, logic [4:0] rd, logic [31:0] wd);
        commit_t c;
        c.pc = pc; c.wen = wen; c.rd = rd; c.wdata = wd;
        return c;
    endfunction

    function automatic commit_t cseq(int i);
        return mk(32'h8000_0000 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(i));
    endfunction

    function automatic int classify(commit_t d, commit_t r);
        bit dw, rw;
        dw = d.wen && d.rd != 0;
        rw = r.wen && r.rd != 0;
        if (d.pc != r.pc) return 1;
        if (dw != rw) return 2;
        if (dw && (d.rd != r.rd || d.wdata != r.wdata)) return 2;
        return 0;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_halt = 0; m_cnt = 0; m_code = 0;
        m_epc = 0; m_edut = 0; m_eref = 0;
    endtask

    task automatic model_step(bit en, bit dv, commit_t dc, bit rv, commit_t rc);
        bit      pop;
        int      code;
        commit_t h;
        if (m_halt) return;
        if (!m_run) begin
            m_run = en;
            return;
        end
        pop = rv && mq.size() != 0;
        if (pop) begin
            h = mq.pop_front();
            code = classify(h, rc);
            if (code != 0) begin
                m_halt = 1; m_code = code;
                m_epc = h.pc; m_edut = h.wdata; m_eref = rc.wdata;
                return;
            end
            m_cnt++;
        end
        if (dv) begin
            if (mq.size() == DEPTH) begin
                m_halt = 1; m_code = 3; m_epc = dc.pc; m_edut = 0; m_eref = 0;
                return;
            end
            mq.push_back(dc);
        end
        if (!en) begin
            mq.delete();
            m_run = 0;
        end
    endtask

    task automatic check_model();
        check("model.halt", halt, m_halt);
        check("model.err_code", err_code, m_code);
        check("model.err_pc", err_pc, m_epc);
        check("model.err_dut_data", err_dut_data, m_edut);
        check("model.err_ref_data", err_ref_data, m_eref);
        check("model.match_cnt", match_cnt, m_cnt);
        check("model.fifo_level", fifo_level, mq.size());
        check("model.ref_ready", bus.ref_ready, m_run && !m_halt && mq.size() != 0);
    endtask

    // Drive one cycle of inputs at edge+1, then sample at the next edge+1.
    task automatic tick(bit en, bit dv, commit_t dc, bit rv, commit_t rc);
        enable = en;
        bus.dut_valid = dv; bus.dut_pc = dc.pc; bus.dut_wen = dc.wen;
        bus.dut_rd = dc.rd; bus.dut_wdata = dc.wdata;
        bus.ref_valid = rv; bus.ref_pc = rc.pc; bus.ref_wen = rc.wen;
        bus.ref_rd = rc.rd; bus.ref_wdata = rc.wdata;
        @(posedge clk);
        model_step(en, dv, dc, rv, rc);
        #1;
        check_model();
    endtask

    // Assert reset between edges and confirm outputs clear before any edge.
    task automatic do_reset();
        enable = 0; bus.dut_valid = 0; bus.ref_valid = 0;
        rst = 1;
        #1;
        check("async_rst.halt", halt, 0);
        check("async_rst.err_code", err_code, 0);
        check("async_rst.err_pc", err_pc, 0);
        check("async_rst.err_data", {err_dut_data, err_ref_data}, 0);
        check("async_rst.match_cnt", match_cnt, 0);
        check("async_rst.fifo_level", fifo_level, 0);
        check("async_rst.ref_ready", bus.ref_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    vec_t    tbl[$];
    commit_t nil;

    function automatic vec_t v(bit r, bit en, bit dv, commit_t dc, bit rv, commit_t rc,
                               bit eh, int ec, logic [31:0] ep, logic [31:0] ed,
                               logic [31:0] er, int cnt, int lvl, bit rdy);
        vec_t x;
        x.do_rst = r; x.en = en; x.dv = dv; x.dc = dc; x.rv = rv; x.rc = rc;
        x.e_halt = eh; x.e_code = ec; x.e_pc = ep; x.e_dut = ed; x.e_ref = er;
        x.e_cnt = cnt; x.e_level = lvl; x.e_ready = rdy;
        return x;
    endfunction

    initial begin
        commit_t dc, rc, p;
        bit en, dv, rv;
        int sel;
        logic [31:0] pc_ctr;

        nil = mk(0, 0, 0, 0);
        rst = 1; enable = 0;
        bus.dut_valid = 0; bus.dut_pc = 0; bus.dut_wen = 0; bus.dut_rd = 0; bus.dut_wdata = 0;
        bus.ref_valid = 0; bus.ref_pc = 0; bus.ref_wen = 0; bus.ref_rd = 0; bus.ref_wdata = 0;
        do_reset();

        // ---- table: plan items 1, 3 and 2 ----
        tbl.push_back(v(0, 1, 0, nil, 0, nil, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 1, 1, cseq(i), 0, nil, 0, 0, 0, 0, 0, 0, i + 1, 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 1, 0, nil, 1, cseq(i), 0, 0, 0, 0, 0, i + 1, 4 - i, i != 4));
        tbl.push_back(v(0, 1, 1, mk(32'h8000_0100, 1, 0, 32'h55), 0, nil, 0, 0, 0, 0, 0, 5, 1, 1));
        tbl.push_back(v(0, 1, 0, nil, 1, mk(32'h8000_0100, 0, 9, 32'h77), 0, 0, 0, 0, 0, 6, 0, 0));
        tbl.push_back(v(1, 1, 0, nil, 0, nil, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0, 1, 1, cseq(i), 0, nil, 0, 0, 0, 0, 0, 0, i + 1, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 1, 0, nil, 1, cseq(i), 0, 0, 0, 0, 0, i + 1, 3 - i, 1));
        tbl.push_back(v(0, 1, 0, nil, 1, mk(32'h8000_000C, 1, 4, 32'hDEAD_BEEF),
                        1, 2, 32'h8000_000C, 3, 32'hDEAD_BEEF, 3, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].do_rst) do_reset();
            tick(tbl[k].en, tbl[k].dv, tbl[k].dc, tbl[k].rv, tbl[k].rc);
            check($sformatf("vec%0d.halt", k), halt, tbl[k].e_halt);
            check($sformatf("vec%0d.err_code", k), err_code, tbl[k].e_code);
            check($sformatf("vec%0d.err_pc", k), err_pc, tbl[k].e_pc);
            check($sformatf("vec%0d.err_dut_data", k), err_dut_data, tbl[k].e_dut);
            check($sformatf("vec%0d.err_ref_data", k), err_ref_data, tbl[k].e_ref);
            check($sformatf("vec%0d.match_cnt", k), match_cnt, tbl[k].e_cnt);
            check($sformatf("vec%0d.fifo_level", k), fifo_level, tbl[k].e_level);
            check($sformatf("vec%0d.ref_ready", k), bus.ref_ready, tbl[k].e_ready);
            $display("vec %0d: dv=%0b rv=%0b -> halt=%0b code=%0d cnt=%0d level=%0d",
                     k, tbl[k].dv, tbl[k].rv, halt, err_code, match_cnt, fifo_level);
        end

        // ---- overflow on the 9th push ----
        do_reset();
        tick(1, 0, nil, 0, nil);
        for (int i = 0; i < 8; i++) tick(1, 1, mk(32'h8000_1000 + 32'(4 * i), 1, 1, 32'(i)), 0, nil);
        check("ovf.level_full", fifo_level, 8);
        tick(1, 1, mk(32'h8000_1020, 1, 1, 32'h8), 0, nil);
        check("ovf.halt", halt, 1);
        check("ovf.err_code", err_code, 3);
        check("ovf.err_pc", err_pc, 32'h8000_1020);
        check("ovf.err_data", {err_dut_data, err_ref_data}, 0);
        $display("seq overflow: code=%0d err_pc=0x%08h", err_code, err_pc);

        // ---- push and pop together at full ----
        do_reset();
        tick(1, 0, nil, 0, nil);
        for (int i = 0; i < 8; i++) tick(1, 1, mk(32'h8000_1000 + 32'(4 * i), 1, 1, 32'(i)), 0, nil);
        tick(1, 1, mk(32'h8000_1020, 1, 1, 32'h8), 1, mk(32'h8000_1000, 1, 1, 32'h0));
        check("full_pushpop.halt", halt, 0);
        check("full_pushpop.err_code", err_code, 0);
        check("full_pushpop.level", fifo_level, 8);
        check("full_pushpop.match_cnt", match_cnt, 1);
        $display("seq full push+pop: level=%0d cnt=%0d", fifo_level, match_cnt);

        // ---- PC mismatch, then halt is sticky ----
        do_reset();
        tick(1, 0, nil, 0, nil);
        tick(1, 1, mk(32'h8000_0000, 1, 1, 32'h11), 0, nil);
        tick(1, 0, nil, 1, mk(32'h8000_0004, 1, 1, 32'h11));
        check("pcmis.err_code", err_code, 1);
        check("pcmis.err_pc", err_pc, 32'h8000_0000);
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, mk(32'h9000_0000, 1, 2, 32'h22), 1, mk(32'h9000_0000, 1, 2, 32'h22));
            check("pcmis.sticky_ready", bus.ref_ready, 0);
            check("pcmis.sticky_code", err_code, 1);
            check("pcmis.sticky_pc", err_pc, 32'h8000_0000);
            check("pcmis.sticky_level", fifo_level, 0);
        end
        $display("seq pc mismatch: halt=%0b code=%0d err_pc=0x%08h", halt, err_code, err_pc);

        // ---- enable flush keeps match_cnt; reset mid-run ----
        do_reset();
        tick(1, 0, nil, 0, nil);
        tick(1, 1, cseq(0), 0, nil);
        tick(1, 0, nil, 1, cseq(0));
        for (int i = 1; i < 4; i++) tick(1, 1, cseq(i), 0, nil);
        check("flush.level_before", fifo_level, 3);
        tick(0, 0, nil, 0, nil);
        check("flush.level", fifo_level, 0);
        check("flush.match_cnt", match_cnt, 1);
        tick(1, 0, nil, 0, nil);
        tick(1, 1, cseq(5), 0, nil);
        check("flush.rerun_level", fifo_level, 1);
        tick(1, 1, cseq(6), 0, nil);
        $display("seq flush: level=%0d cnt=%0d", fifo_level, match_cnt);
        do_reset();

        // ---- randomized run against the model ----
        pc_ctr = 32'h8000_2000;
        tick(1, 0, nil, 0, nil);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (m_halt && $urandom_range(0, 3) == 0) begin
                $display("rand cyc %0d: halted with code %0d, resetting", cyc, m_code);
                do_reset();
            end
            en = $urandom_range(0, 39) != 0;
            dv = $urandom_range(0, 1);
            dc = mk(pc_ctr, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            pc_ctr += 4;
            rv = $urandom_range(0, 9) < 6;
            if (mq.size() != 0) begin
                p = mq[0];
                rc = p;
                // Equivalent encodings of "no write" must still match.
                if (!(p.wen && p.rd != 0)) begin
                    rc.wen = $urandom_range(0, 1);
                    rc.rd = rc.wen ? 5'd0 : 5'($urandom_range(0, 31));
                    rc.wdata = $urandom;
                end
                if ($urandom_range(0, 59) == 0) begin
                    sel = $urandom_range(0, 3);
                    case (sel)
                        0: rc.pc = rc.pc ^ 32'h4;
                        1: rc.wdata = rc.wdata ^ 32'h1;
                        2: rc.rd = rc.rd ^ 5'h1;
                        default: rc.wen = !rc.wen;
                    endcase
                end
            end else begin
                rc = mk($urandom, 1, 5'($urandom_range(0, 31)), $urandom);
            end
            tick(en, dv, dc, rv, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
